// File: rtl/arc4_pkg.sv
// arc4_pkg -- shared types and constants for the ARC4 decrypt controller.
//   ctrl_state_t : sequencer states (three phases, each START/GAP/WAIT)
//   s_owner_t    : which engine currently owns the single-port S memory
//   phase_owner  : owner implied by a state (NONE outside the phases)
//   phase_next   : successor of a state along the nominal path
package arc4_pkg;

  localparam int S_AW  = 8;
  localparam int S_DW  = 8;
  localparam int N_ENG = 3;   // init, ksa, prga; lane index = owner - 1

  typedef enum logic [3:0] {
    IDLE,
    INIT_START, INIT_GAP, INIT_WAIT,
    KSA_START,  KSA_GAP,  KSA_WAIT,
    PRGA_START, PRGA_GAP, PRGA_WAIT,
    DONE,
    ERR
  } ctrl_state_t;

  typedef enum logic [1:0] {
    NONE,
    INIT,
    KSA,
    PRGA
  } s_owner_t;

  function automatic s_owner_t phase_owner(input ctrl_state_t s);
    case (s)
      INIT_START, INIT_GAP, INIT_WAIT: return INIT;
      KSA_START,  KSA_GAP,  KSA_WAIT:  return KSA;
      PRGA_START, PRGA_GAP, PRGA_WAIT: return PRGA;
      default:                         return NONE;
    endcase
  endfunction

  // The last WAIT of each phase chains into the next phase's START,
  // and the PRGA phase falls through to DONE.
  function automatic ctrl_state_t phase_next(input ctrl_state_t s);
    case (s)
      INIT_START: return INIT_GAP;
      INIT_GAP:   return INIT_WAIT;
      INIT_WAIT:  return KSA_START;
      KSA_START:  return KSA_GAP;
      KSA_GAP:    return KSA_WAIT;
      KSA_WAIT:   return PRGA_START;
      PRGA_START: return PRGA_GAP;
      PRGA_GAP:   return PRGA_WAIT;
      PRGA_WAIT:  return DONE;
      default:    return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/arc4_ctrl_if.sv
// arc4_ctrl_if -- bundle of everything the controller talks to except clk/rst.
//   host side   : en, key in; rdy, key_q, err out
//   engine side : x_rdy, x_s_addr, x_s_wrdata, x_s_wren in; x_en out
//   S memory    : s_addr, s_wrdata, s_wren out
// Modport slave is the controller's view; master is the surroundings
// (host + engines + memory) as seen by whoever drives them.
interface arc4_ctrl_if #(
  parameter int KEY_W = 24
);
  import arc4_pkg::*;

  logic             en;
  logic             rdy;
  logic [KEY_W-1:0] key;
  logic [KEY_W-1:0] key_q;
  logic             err;

  logic             init_en,  ksa_en,  prga_en;
  logic             init_rdy, ksa_rdy, prga_rdy;
  logic [S_AW-1:0]  init_s_addr,   ksa_s_addr,   prga_s_addr;
  logic [S_DW-1:0]  init_s_wrdata, ksa_s_wrdata, prga_s_wrdata;
  logic             init_s_wren,   ksa_s_wren,   prga_s_wren;

  logic [S_AW-1:0]  s_addr;
  logic [S_DW-1:0]  s_wrdata;
  logic             s_wren;

  modport slave (
    input  en, key,
    input  init_rdy, ksa_rdy, prga_rdy,
    input  init_s_addr, ksa_s_addr, prga_s_addr,
    input  init_s_wrdata, ksa_s_wrdata, prga_s_wrdata,
    input  init_s_wren, ksa_s_wren, prga_s_wren,
    output rdy, key_q, err,
    output init_en, ksa_en, prga_en,
    output s_addr, s_wrdata, s_wren
  );

  modport master (
    output en, key,
    output init_rdy, ksa_rdy, prga_rdy,
    output init_s_addr, ksa_s_addr, prga_s_addr,
    output init_s_wrdata, ksa_s_wrdata, prga_s_wrdata,
    output init_s_wren, ksa_s_wren, prga_s_wren,
    input  rdy, key_q, err,
    input  init_en, ksa_en, prga_en,
    input  s_addr, s_wrdata, s_wren
  );

endinterface

// File: rtl/arc4_ctrl_s_port_mux.sv
// s_port_mux -- combinational 3:1 mux of engine S-port requests onto the
// single-port S memory.
//   owner      : registered grant from the sequencer
//   eng_*      : per-engine address / write data / write enable, lane 0=init,
//                1=ksa, 2=prga
//   s_*        : memory-side request; all zero when owner is NONE, so a
//                non-owner write enable can never reach the array
module s_port_mux
  import arc4_pkg::*;
(
  input  s_owner_t                    owner,
  input  logic [N_ENG-1:0][S_AW-1:0]  eng_addr,
  input  logic [N_ENG-1:0][S_DW-1:0]  eng_wrdata,
  input  logic [N_ENG-1:0]            eng_wren,
  output logic [S_AW-1:0]             s_addr,
  output logic [S_DW-1:0]             s_wrdata,
  output logic                        s_wren
);

  always_comb begin
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    for (int i = 0; i < N_ENG; i++) begin
      if (owner == s_owner_t'(i + 1)) begin
        s_addr   = eng_addr[i];
        s_wrdata = eng_wrdata[i];
        s_wren   = eng_wren[i];
      end
    end
  end

endmodule

// File: rtl/arc4_ctrl.sv
// arc4_ctrl -- top-level sequencer for the ARC4 decrypt datapath.
// One accepted start runs init, ksa and prga in order, each via an en/rdy
// handshake, while arbitrating the single-port S memory for whichever engine
// is active. A per-phase watchdog converts a hung engine into a sticky err.
//   clk, rst : clock, synchronous active-high reset
//   bus      : arc4_ctrl_if.slave -- host en/rdy/key/key_q/err, engine
//              x_en/x_rdy and S requests, muxed S-memory port
// Per phase: START holds until the engine is idle and fires x_en for exactly
// that cycle, GAP skips the cycle in which the engine has not yet dropped
// rdy, WAIT watches for completion and counts toward the timeout.
module arc4_ctrl
  import arc4_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int KEY_W          = 24
) (
  input logic        clk,
  input logic        rst,
  arc4_ctrl_if.slave bus
);

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  ctrl_state_t      state;
  ctrl_state_t      nxt;
  s_owner_t         owner;
  logic [15:0]      wd;
  logic             cur_rdy;
  logic             rdy_q;
  logic             err_q;
  logic [KEY_W-1:0] key_q;

  assign nxt = phase_next(state);

  // rdy of the engine belonging to the current phase
  always_comb begin
    cur_rdy = 1'b0;
    case (phase_owner(state))
      INIT:    cur_rdy = bus.init_rdy;
      KSA:     cur_rdy = bus.ksa_rdy;
      PRGA:    cur_rdy = bus.prga_rdy;
      default: cur_rdy = 1'b0;
    endcase
  end

  // Start pulses are gated by the engine's own rdy so a busy engine
  // simply holds the sequencer in START without a pulse.
  assign bus.init_en = (state == INIT_START) & bus.init_rdy;
  assign bus.ksa_en  = (state == KSA_START)  & bus.ksa_rdy;
  assign bus.prga_en = (state == PRGA_START) & bus.prga_rdy;

  assign bus.rdy   = rdy_q;
  assign bus.err   = err_q;
  assign bus.key_q = key_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= NONE;
      rdy_q <= 1'b1;
      err_q <= 1'b0;
      key_q <= '0;
      wd    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en) begin
            key_q <= bus.key;
            err_q <= 1'b0;
            rdy_q <= 1'b0;
            owner <= INIT;     // grant before the pulse so first access is live
            state <= INIT_START;
          end
        end
        INIT_START, KSA_START, PRGA_START: begin
          if (cur_rdy) state <= nxt;
        end
        INIT_GAP, KSA_GAP, PRGA_GAP: begin
          wd    <= '0;
          state <= nxt;
        end
        INIT_WAIT, KSA_WAIT, PRGA_WAIT: begin
          if (cur_rdy) begin
            state <= nxt;
            owner <= phase_owner(nxt);   // next engine, or NONE into DONE
          end else if (wd == WD_LAST) begin
            state <= ERR;
            owner <= NONE;
            err_q <= 1'b1;
          end else begin
            wd <= wd + 16'd1;
          end
        end
        DONE, ERR: begin
          state <= IDLE;
          rdy_q <= 1'b1;
        end
        default: begin
          state <= IDLE;
          owner <= NONE;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

  s_port_mux u_mux (
    .owner      (owner),
    .eng_addr   ({bus.prga_s_addr,   bus.ksa_s_addr,   bus.init_s_addr}),
    .eng_wrdata ({bus.prga_s_wrdata, bus.ksa_s_wrdata, bus.init_s_wrdata}),
    .eng_wren   ({bus.prga_s_wren,   bus.ksa_s_wren,   bus.init_s_wren}),
    .s_addr     (bus.s_addr),
    .s_wrdata   (bus.s_wrdata),
    .s_wren     (bus.s_wren)
  );

endmodule

// File: tb/tb_arc4_ctrl.sv
// tb_arc4_ctrl -- scoreboard bench for arc4_ctrl.
// Two controllers: dut (default timeout) and dut_wd (timeout 16). Mock engines
// drop rdy the cycle after their en and raise it again after m_lat cycles;
// m_hold masks a mock's rdy, m_hang keeps it low. Stimulus pushes expected
// events (engine pulses, rdy return) into exp_q; the monitor pops them as the
// main DUT produces them.
module tb_arc4_ctrl;
  import arc4_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arc4_ctrl_if #(.KEY_W(24)) a ();
  arc4_ctrl_if #(.KEY_W(24)) w ();

  arc4_ctrl #(.TIMEOUT_CYCLES(65535), .KEY_W(24)) dut (
    .clk (clk), .rst (rst), .bus (a.slave)
  );
  arc4_ctrl #(.TIMEOUT_CYCLES(16), .KEY_W(24)) dut_wd (
    .clk (clk), .rst (rst), .bus (w.slave)
  );

  // ---------------- mock engines: 0..2 main, 3..5 watchdog DUT -------------
  logic [5:0] m_en, m_rdy, m_hold, m_hang;
  int         m_lat [6];
  int         m_cnt [6];

  assign m_en = {w.prga_en, w.ksa_en, w.init_en, a.prga_en, a.ksa_en, a.init_en};

  always @(posedge clk) begin
    for (int g = 0; g < 6; g++) begin
      if (rst) begin
        m_rdy[g] <= 1'b1;
        m_cnt[g] <= 0;
      end else if (m_en[g]) begin
        m_rdy[g] <= 1'b0;
        m_cnt[g] <= m_lat[g] - 1;
      end else if (!m_rdy[g] && !m_hang[g]) begin
        if (m_cnt[g] == 0) m_rdy[g] <= 1'b1;
        else               m_cnt[g] <= m_cnt[g] - 1;
      end
    end
  end

  assign a.init_rdy = m_rdy[0] & ~m_hold[0];
  assign a.ksa_rdy  = m_rdy[1] & ~m_hold[1];
  assign a.prga_rdy = m_rdy[2] & ~m_hold[2];
  assign w.init_rdy = m_rdy[3] & ~m_hold[3];
  assign w.ksa_rdy  = m_rdy[4] & ~m_hold[4];
  assign w.prga_rdy = m_rdy[5] & ~m_hold[5];

  // every engine requests writes all the time, with distinct addresses
  assign a.init_s_addr = 8'h11; assign a.init_s_wrdata = 8'hA1; assign a.init_s_wren = 1'b1;
  assign a.ksa_s_addr  = 8'h22; assign a.ksa_s_wrdata  = 8'hA2; assign a.ksa_s_wren  = 1'b1;
  assign a.prga_s_addr = 8'h33; assign a.prga_s_wrdata = 8'hA3; assign a.prga_s_wren = 1'b1;
  assign w.init_s_addr = 8'h11; assign w.init_s_wrdata = 8'hA1; assign w.init_s_wren = 1'b1;
  assign w.ksa_s_addr  = 8'h22; assign w.ksa_s_wrdata  = 8'hA2; assign w.ksa_s_wren  = 1'b1;
  assign w.prga_s_addr = 8'h33; assign w.prga_s_wrdata = 8'hA3; assign w.prga_s_wren = 1'b1;

  // ---------------- scoreboard ----------------------------------------------
  typedef struct {
    int          kind;   // 0 init_en, 1 ksa_en, 2 prga_en, 3 rdy returns
    int          cyc;    // expected cycle of rdy return, -1 = not checked
    logic [23:0] key;
  } ev_t;

  ev_t  exp_q [$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   w_prga_cnt = 0;
  logic rst_d = 1'b1;
  logic rdy_d = 1'b1;
  logic wren_d = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
    if (w.prga_en) w_prga_cnt <= w_prga_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [23:0] k);
    ev_t e;
    e.kind = kind; e.cyc = c; e.key = k;
    exp_q.push_back(e);
  endtask

  task automatic mon_event(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d, expected none (cycle %0d)", kind, cyc);
      return;
    end
    e = exp_q.pop_front();
    chk("event_order", kind, e.kind);
    chk("key_q_at_event", a.key_q, e.key);
    if (kind < 3) begin
      chk("s_addr_owner", a.s_addr, 32'(8'h11 * (kind + 1)));
      chk("s_wren_owner", a.s_wren, 1);
    end else begin
      chk("err_at_done", a.err, 0);
      chk("s_wren_in_done", wren_d, 0);
      if (e.cyc >= 0) chk("rdy_return_cycle", cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (a.init_en) mon_event(0);
    if (a.ksa_en)  mon_event(1);
    if (a.prga_en) mon_event(2);
    if (a.rdy && !rdy_d && !rst_d) mon_event(3);
    rdy_d  = a.rdy;
    wren_d = a.s_wren;
  end

  // ---------------- stimulus helpers ----------------------------------------
  // exp_off < 0: don't check the rdy-return cycle; with_done=0: no rdy event
  task automatic start_main(input logic [23:0] k, input int exp_off, input bit with_done);
    @(negedge clk);
    a.en = 1'b1;
    a.key = k;
    push(0, -1, k);
    push(1, -1, k);
    push(2, -1, k);
    if (with_done) push(3, (exp_off < 0) ? -1 : cyc + 1 + exp_off, k);
    @(negedge clk);
    a.en  = 1'b0;
    a.key = 24'hFFFFFF;          // must not leak into key_q
  endtask

  task automatic drain(input string nm, input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    #3;
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic wait_addr(input string nm, input logic [7:0] ad, input int bound);
    int n = 0;
    @(negedge clk); #1;
    while (a.s_addr != ad && n < bound) begin
      @(negedge clk); #1;
      n++;
    end
    chk(nm, a.s_addr, ad);
  endtask

  // ---------------- main sequence -------------------------------------------
  initial begin
    int kc, n;
    rst = 1'b1;
    a.en = 1'b0; a.key = '0;
    w.en = 1'b0; w.key = '0;
    m_hold = '0; m_hang = '0;
    for (int i = 0; i < 6; i++) m_lat[i] = 4;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdy", a.rdy, 1);
    chk("rst_err", a.err, 0);
    chk("rst_key_q", a.key_q, 0);
    chk("rst_s_addr", a.s_addr, 0);
    chk("rst_s_wrdata", a.s_wrdata, 0);
    chk("rst_s_wren", a.s_wren, 0);
    chk("rst_engine_en", {a.init_en, a.ksa_en, a.prga_en}, 0);
    @(negedge clk);
    rst = 1'b0;

    // nominal run: latencies 256/768/300, rdy back sum+7 edges after accept
    m_lat[0] = 256; m_lat[1] = 768; m_lat[2] = 300;
    start_main(24'h00033C, 256 + 768 + 300 + 7, 1'b1);
    drain("nominal_complete", 2000);
    chk("idle_s_wren", a.s_wren, 0);
    chk("idle_key_q_held", a.key_q, 24'h00033C);

    // ksa not ready for 5 cycles after init completes
    m_lat[0] = 10; m_lat[1] = 20; m_lat[2] = 10;
    m_hold[1] = 1'b1;
    start_main(24'hABCDEF, -1, 1'b1);
    wait_addr("reach_ksa_start", 8'h22, 100);
    chk("ksa_held_en", a.ksa_en, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("ksa_held_en", a.ksa_en, 0);
      chk("ksa_held_owner", a.s_addr, 8'h22);
    end
    @(negedge clk);
    m_hold[1] = 1'b0;
    #1;
    chk("ksa_en_on_rdy", a.ksa_en, 1);
    drain("hold_complete", 200);

    // watchdog on the timeout-16 controller: ksa accepts en, never finishes
    m_hang[4] = 1'b1;
    m_lat[3] = 4; m_lat[4] = 5; m_lat[5] = 3;
    @(negedge clk);
    w.en = 1'b1; w.key = 24'h000001;
    @(negedge clk);
    w.en = 1'b0;
    #1;
    chk("wd_busy", w.rdy, 0);
    kc = -1000; n = 0;
    while (!w.rdy && n < 200) begin
      if (w.ksa_en) kc = cyc;
      @(negedge clk); #1;
      n++;
    end
    chk("wd_rdy_back", w.rdy, 1);
    chk("wd_err", w.err, 1);
    chk("wd_wait_cycles", cyc - kc, 19);   // START, GAP, 16 WAIT, ERR
    chk("wd_no_prga_en", w_prga_cnt, 0);
    chk("wd_err_s_wren", w.s_wren, 0);
    // next en clears err and restarts at init
    @(negedge clk);
    m_hang[4] = 1'b0;
    w.en = 1'b1; w.key = 24'h000002;
    @(negedge clk);
    w.en = 1'b0;
    #1;
    chk("wd_err_cleared", w.err, 0);
    chk("wd_restart_init_en", w.init_en, 1);
    chk("wd_restart_key_q", w.key_q, 24'h000002);
    n = 0;
    while (!w.rdy && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("wd_rerun_done", w.rdy, 1);
    chk("wd_rerun_err", w.err, 0);

    // en during KSA is ignored, then reset mid-PRGA
    m_lat[0] = 10; m_lat[1] = 40; m_lat[2] = 60;
    start_main(24'h123456, -1, 1'b0);
    wait_addr("reach_ksa", 8'h22, 100);
    repeat (3) @(negedge clk);
    a.en = 1'b1; a.key = 24'h777777;
    @(negedge clk);
    a.en = 1'b0;
    #1;
    chk("ignored_en_rdy", a.rdy, 0);
    chk("ignored_en_key_q", a.key_q, 24'h123456);
    wait_addr("reach_prga", 8'h33, 200);
    chk("prga_owner_wren", a.s_wren, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrun_rst_rdy", a.rdy, 1);
    chk("midrun_rst_s_wren", a.s_wren, 0);
    chk("midrun_rst_en", {a.init_en, a.ksa_en, a.prga_en}, 0);
    chk("midrun_rst_key_q", a.key_q, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/arc4_ctrl.md
Name: arc4_ctrl

Overview:
Top-level sequencer for the ARC4 decrypt datapath. On one start request it runs three engines in order, each under its own en/rdy handshake: init (S[i]=i), then ksa, then prga. It is also the sole arbiter of the single-port S memory, muxing the active engine's address, write data and write enable onto it. A per-phase watchdog turns a hung engine into a reported error instead of a deadlock.

Parameters:
TIMEOUT_CYCLES, 65535, max cycles a phase may hold rdy low before err; counter is 16 bits.
KEY_W, 24, key width.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
en  in  1  start request; accepted only in a cycle where rdy=1
rdy  out  1  controller idle, able to accept en
key  in  KEY_W  key, sampled in the en-accept cycle
key_q  out  KEY_W  latched key to ksa/prga
err  out  1  sticky watchdog error; cleared by the next accepted en
init_en / ksa_en / prga_en  out  1 each  engine start pulses
init_rdy / ksa_rdy / prga_rdy  in  1 each  engine idle flags
init_s_addr, ksa_s_addr, prga_s_addr  in  8 each  engine S address
init_s_wrdata, ksa_s_wrdata, prga_s_wrdata  in  8 each  engine S write data
init_s_wren, ksa_s_wren, prga_s_wren  in  1 each  engine S write enable
s_addr  out  8  to S memory
s_wrdata  out  8  to S memory
s_wren  out  1  to S memory

s_rddata fans out directly to all engines and is not routed through this block.

Behaviour:
- Reset values: state IDLE, owner NONE, rdy=1, err=0, key_q=0, all *_en=0, s_addr=0, s_wrdata=0, s_wren=0, watchdog=0.
- Reset asserted mid-run returns to IDLE on the next edge. Engines are not reset by this block.
- States:
  - IDLE: rdy=1. On en, latch key_q, clear err, go to INIT_START.
  - X_START (X = INIT, KSA, PRGA): set owner=X. Hold until x_rdy=1. x_en = (state==X_START) & x_rdy, combinational, so it is a single-cycle pulse. In the pulse cycle go to X_GAP.
  - X_GAP: one cycle, watchdog cleared. x_rdy is ignored here because the engine drops rdy only the cycle after en.
  - X_WAIT:
    - x_rdy=1 → next phase START (INIT→KSA, KSA→PRGA, PRGA→DONE).
    - Otherwise increment watchdog. When watchdog reaches TIMEOUT_CYCLES-1 with x_rdy still 0 → ERR.
  - DONE: owner NONE, one cycle, → IDLE.
  - ERR: err←1, owner NONE, one cycle, → IDLE. err stays set until the next accepted en.
- Handshake timing:
  - en accepted at edge T: rdy=0 from T+1.
  - Earliest init_en is at T+1, when init_rdy=1.
  - Controller overhead per phase is 2 cycles (START pulse + GAP) plus engine run time.
  - Completion: rdy returns 1 on the cycle after DONE.
- Requests:
  - en while rdy=0 is ignored; no queuing.
  - en and rst together: rst wins.
- Mux:
  - Combinational from the registered owner.
  - owner NONE → s_wren=0 and s_addr=s_wrdata=0.
  - owner changes only on START entry, so the engine's first access after its en is already granted.
  - A non-owner *_s_wren never reaches memory.
- key_q is stable from the accept edge until the next accepted en; key changes mid-run have no effect.

Decomposition:
- Package arc4_pkg:
  - state enum ctrl_state_t (IDLE, INIT_START, INIT_GAP, INIT_WAIT, KSA_START, KSA_GAP, KSA_WAIT, PRGA_START, PRGA_GAP, PRGA_WAIT, DONE, ERR).
  - owner enum s_owner_t (NONE, INIT, KSA, PRGA).
  - constants S_AW=8, S_DW=8.
- One natural sub-module, s_port_mux: a purely combinational 3:1 S-port mux with a NONE gate, selected by s_owner_t.
- The FSM and watchdog stay in arc4_ctrl.

Test Plan:
- Nominal run. Mock engines with latencies 256, 768, 300 cycles; en pulse with key=24'h00033C.
  - Required: exactly one init_en, then one ksa_en, then one prga_en, in that order.
  - Required: key_q=24'h00033C throughout; rdy high again 256+768+300+6+1 cycles after the accept edge; err=0.
- Arbitration. All mocks drive s_wren=1 with distinct addresses (8'h11/8'h22/8'h33) continuously.
  - Required: s_addr shows only the owner's address in each phase.
  - Required: s_wren=0 in IDLE/DONE.
- Engine not ready. ksa_rdy held 0 for 5 cycles after init completes.
  - Required: controller stays in KSA_START with ksa_en=0.
  - Required: ksa_en pulses once, on the cycle ksa_rdy rises.
- Watchdog. TIMEOUT_CYCLES=16; ksa mock never raises rdy.
  - Required: err=1 and rdy=1 after 16 wait cycles; prga_en never asserted.
  - Required: a following en clears err and restarts from init.
- Ignored request and reset. en pulsed mid-KSA produces no effect.
  - Then rst asserted mid-PRGA: the next edge gives rdy=1, s_wren=0, all *_en=0, key_q=0.
